// File: rtl/smvm_pkg.sv
// smvm_pkg: shared state encoding, pipeline credit and saturating add for smvm_stream.
package smvm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_VEC, STREAM, DRAIN} state_t;
  localparam int PIPE_CREDIT = 3;
  // Clamp a + b to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [63:0] s, hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) ? hi : ((s < lo) ? lo : s);
  endfunction
endpackage

// File: rtl/smvm_out_fifo.sv
// smvm_out_fifo: first-word-fall-through result FIFO with occupancy count.
module smvm_out_fifo #(
  parameter int W = 21,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         not_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_pop;
  assign not_empty = count != '0;
  assign do_pop = pop && not_empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNTW'(push) - CNTW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
  // Upstream credit guarantees this never fires.
  always_ff @(posedge clk) begin
    if (rst_n && push && !do_pop) assert (count != CNTW'(DEPTH));
  end
endmodule

// File: rtl/smvm_stream.sv
// smvm_stream: streaming CSR sparse matrix-vector multiply with preloaded vector,
// 3-stage multiply-accumulate pipeline and credit-protected output FIFO.
module smvm_stream
  import smvm_pkg::*;
#(
  parameter int DW = 8,
  parameter int MAX_COLS = 128,
  parameter int ACC_W = 20,
  parameter int OUT_DEPTH = 8,
  parameter int SAT = 1,
  localparam int CW = $clog2(MAX_COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW:0]      cfg_cols,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [DW-1:0]    vec_data,
  input  logic             nz_valid,
  output logic             nz_ready,
  input  logic [DW-1:0]    nz_val,
  input  logic [CW-1:0]    nz_col,
  input  logic             nz_row_end,
  input  logic             nz_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             err_col
);
  state_t state, state_next;
  logic [CW:0] cols;
  logic [CW-1:0] idx;
  logic cfg_fire, vec_fire, nz_fire, pop, push, vec_end, col_bad;
  logic signed [DW-1:0] vec [MAX_COLS];
  logic s1_valid, s1_row_end, s1_last;
  logic signed [DW-1:0] s1_val, s1_x;
  logic s2_valid, s2_row_end, s2_last;
  logic signed [2*DW-1:0] s2_prod;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic [ACC_W:0] head;
  logic fifo_ne;
  logic [$clog2(OUT_DEPTH+1)-1:0] fifo_count;
  assign cfg_fire = cfg_valid && cfg_ready;
  assign vec_fire = vec_valid && vec_ready;
  assign nz_fire = nz_valid && nz_ready;
  assign pop = out_valid && out_ready;
  assign vec_end = {1'b0, idx} == cols - 1'b1;
  assign col_bad = {1'b0, nz_col} >= cols;
  assign push = s2_valid && s2_row_end;
  assign acc_next = ACC_W'((SAT != 0) ? sat_add(64'(acc), 64'(s2_prod), ACC_W) : 64'(acc) + 64'(s2_prod));
  assign out_valid = fifo_ne;
  assign out_data = fifo_ne ? head[ACC_W-1:0] : '0;
  assign out_last = fifo_ne && head[ACC_W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    cfg_ready = state == IDLE;
    vec_ready = state == LOAD_VEC;
    // Reserve room for every beat that could still be in the pipeline.
    nz_ready = (state == STREAM) && (int'(fifo_count) + PIPE_CREDIT <= OUT_DEPTH);
    case (state)
      IDLE:     state_next = cfg_fire ? LOAD_VEC : IDLE;
      LOAD_VEC: state_next = (vec_fire && vec_end) ? STREAM : LOAD_VEC;
      STREAM:   state_next = (nz_fire && nz_last) ? DRAIN : STREAM;
      DRAIN:    state_next = (pop && out_last && !s1_valid && !s2_valid) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (vec_fire) vec[idx] <= vec_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols <= '0;
      idx <= '0;
      err_col <= 1'b0;
      s1_valid <= 1'b0;
      s1_val <= '0;
      s1_x <= '0;
      s1_row_end <= 1'b0;
      s1_last <= 1'b0;
      s2_valid <= 1'b0;
      s2_prod <= '0;
      s2_row_end <= 1'b0;
      s2_last <= 1'b0;
      acc <= '0;
    end else begin
      if (cfg_fire) cols <= cfg_cols;
      if (vec_fire) idx <= vec_end ? '0 : idx + 1'b1;
      if (cfg_fire) err_col <= 1'b0;
      else if (nz_fire && col_bad) err_col <= 1'b1;
      s1_valid <= nz_fire;
      if (nz_fire) begin
        s1_val <= nz_val;
        s1_x <= col_bad ? '0 : vec[nz_col];
        s1_row_end <= nz_row_end;
        s1_last <= nz_last;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= s1_val * s1_x;
        s2_row_end <= s1_row_end;
        s2_last <= s1_last;
      end
      if (s2_valid) acc <= s2_row_end ? '0 : acc_next;
    end
  end
  smvm_out_fifo #(.W(ACC_W + 1), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({s2_last, acc_next}),
    .pop       (pop),
    .head      (head),
    .not_empty (fifo_ne),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_smvm_stream.sv
// tb_smvm_stream: directed checks of smvm_stream with a saturating and a wrapping
// instance driven in lockstep.
module tb_smvm_stream;
  localparam int DW = 8, MC = 8, AW = 16, OD = 4, CW = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_valid = 0, vec_valid = 0, nz_valid = 0, nz_row_end = 0, nz_last = 0, out_ready = 1;
  logic [CW:0] cfg_cols = '0;
  logic [DW-1:0] vec_data = '0, nz_val = '0;
  logic [CW-1:0] nz_col = '0;
  logic cfg_ready, vec_ready, nz_ready, out_valid, out_last, err_col;
  logic [AW-1:0] out_data;
  logic w_cfg_ready, w_vec_ready, w_nz_ready, w_out_valid, w_out_last, w_err_col;
  logic [AW-1:0] w_out_data;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int first_edge = -1, last_pop_edge = -1, nz_edge = 0, cfg_edge = 0;
  int xv[8];
  logic [AW:0] got_q[$], got1_q[$];
  typedef struct {int val; int col; int exp;} row_t;
  row_t rows[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  smvm_stream #(.DW(DW), .MAX_COLS(MC), .ACC_W(AW), .OUT_DEPTH(OD), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cols(cfg_cols),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val), .nz_col(nz_col),
    .nz_row_end(nz_row_end), .nz_last(nz_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .err_col(err_col));

  smvm_stream #(.DW(DW), .MAX_COLS(MC), .ACC_W(AW), .OUT_DEPTH(OD), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(w_cfg_ready), .cfg_cols(cfg_cols),
    .vec_valid(vec_valid), .vec_ready(w_vec_ready), .vec_data(vec_data),
    .nz_valid(nz_valid), .nz_ready(w_nz_ready), .nz_val(nz_val), .nz_col(nz_col),
    .nz_row_end(nz_row_end), .nz_last(nz_last), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_last(w_out_last), .err_col(w_err_col));

  // Record every popped result, and the edge numbers of the first and last pops.
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      got1_q.push_back({w_out_last, w_out_data});
      if (first_edge < 0) first_edge = cyc + 1;
      if (out_last) last_pop_edge = cyc + 1;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_cfg(input int cols);
    cfg_cols = 4'(cols);
    cfg_valid = 1'b1;
    for (int i = 0; i < 200 && !cfg_ready; i++) @(negedge clk);
    chk("cfg_ready", int'(cfg_ready), 1);
    cfg_edge = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic load_vec(input int n);
    for (int k = 0; k < n; k++) begin
      vec_data = 8'(xv[k]);
      vec_valid = 1'b1;
      for (int i = 0; i < 200 && !vec_ready; i++) @(negedge clk);
      chk("vec_ready", int'(vec_ready), 1);
      @(posedge clk);
      @(negedge clk);
    end
    vec_valid = 1'b0;
  endtask

  task automatic send_nz(input int val, input int col, input bit re, input bit last);
    nz_val = 8'(val);
    nz_col = 3'(col);
    nz_row_end = re;
    nz_last = last;
    nz_valid = 1'b1;
    for (int i = 0; i < 200 && !nz_ready; i++) @(negedge clk);
    chk("nz_ready", int'(nz_ready), 1);
    nz_edge = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    nz_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 200 && got_q.size() < n; i++) begin
      @(negedge clk);
      #2;
    end
    chk("result_count", got_q.size(), n);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !cfg_ready; i++) @(negedge clk);
    chk("idle", int'(cfg_ready), 1);
  endtask

  function automatic int dat(input logic [AW:0] e);
    return int'($signed(e[AW-1:0]));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rowend_edge;
    rows[0] = '{10, 0, 30};
    rows[1] = '{-3, 1, 15};
    rows[2] = '{127, 3, -16256};
    rows[3] = '{-128, 3, 16384};
    rows[4] = '{-128, 4, -16256};
    rows[5] = '{5, 5, 0};
    rows[6] = '{-7, 6, -7};
    rows[7] = '{100, 7, -100};

    #1;
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_vec_ready", int'(vec_ready), 0);
    chk("rst_nz_ready", int'(nz_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_err_col", int'(err_col), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 2x3 job
    got_q.delete(); got1_q.delete(); first_edge = -1;
    do_cfg(3);
    xv[0] = 1; xv[1] = 2; xv[2] = 3;
    load_vec(3);
    send_nz(2, 0, 0, 0);
    send_nz(-1, 2, 1, 0);
    rowend_edge = nz_edge;
    send_nz(4, 1, 1, 1);
    wait_results(2);
    chk("basic_latency", first_edge, rowend_edge + 3);
    chk("basic_r0", dat(got_q[0]), -1);
    chk("basic_r0_last", int'(got_q[0][AW]), 0);
    chk("basic_r1", dat(got_q[1]), 8);
    chk("basic_r1_last", int'(got_q[1][AW]), 1);
    wait_idle();

    // Saturation vs wrap
    got_q.delete(); got1_q.delete();
    do_cfg(1);
    xv[0] = 127;
    load_vec(1);
    send_nz(127, 0, 0, 0);
    send_nz(127, 0, 0, 0);
    send_nz(127, 0, 1, 1);
    wait_results(1);
    chk("sat_value", dat(got_q[0]), 32767);
    chk("wrap_value", dat(got1_q[0]), -17149);
    chk("wrap_last", int'(got1_q[0][AW]), 1);
    wait_idle();

    // Backpressure with a 4-entry FIFO
    got_q.delete(); got1_q.delete();
    out_ready = 1'b0;
    do_cfg(8);
    xv = '{3, -5, 7, -128, 127, 0, 1, -1};
    load_vec(8);
    for (int i = 0; i < 4; i++) send_nz(rows[i].val, rows[i].col, 1, 0);
    nz_val = 8'(rows[4].val); nz_col = 3'(rows[4].col); nz_row_end = 1'b1; nz_last = 1'b0;
    nz_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_stall_nz_ready", int'(nz_ready), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_nothing_popped", got_q.size(), 0);
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) send_nz(rows[i].val, rows[i].col, 1, i == 7);
    wait_results(8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_row%0d", i), dat(got_q[i]), rows[i].exp);
      chk($sformatf("bp_last%0d", i), int'(got_q[i][AW]), int'(i == 7));
    end
    wait_idle();

    // Out-of-range column
    got_q.delete(); got1_q.delete();
    do_cfg(2);
    xv[0] = 4; xv[1] = 5;
    load_vec(2);
    send_nz(9, 5, 1, 1);
    chk("oor_err_set", int'(err_col), 1);
    wait_results(1);
    chk("oor_value", dat(got_q[0]), 0);
    wait_idle();
    chk("oor_err_sticky", int'(err_col), 1);

    // Empty row, then a cfg held through DRAIN
    got_q.delete(); got1_q.delete();
    do_cfg(1);
    chk("err_cleared", int'(err_col), 0);
    xv[0] = 7;
    load_vec(1);
    out_ready = 1'b0;
    send_nz(0, 0, 1, 0);
    send_nz(3, 0, 1, 1);
    cfg_cols = 4'd2;
    cfg_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("b2b_cfg_blocked", int'(cfg_ready), 0);
    out_ready = 1'b1;
    do_cfg(2);
    chk("b2b_accept_edge", cfg_edge, last_pop_edge + 1);
    chk("empty_row", dat(got_q[0]), 0);
    chk("b2b_r1", dat(got_q[1]), 21);
    got_q.delete(); got1_q.delete();
    xv[0] = -3; xv[1] = 6;
    load_vec(2);
    send_nz(5, 0, 0, 0);
    send_nz(2, 1, 1, 1);
    wait_results(1);
    chk("b2b_job2", dat(got_q[0]), -3);
    wait_idle();

    // Reset mid-job with results buffered
    got_q.delete(); got1_q.delete();
    do_cfg(1);
    xv[0] = 2;
    load_vec(1);
    out_ready = 1'b0;
    send_nz(1, 0, 1, 0);
    send_nz(2, 0, 1, 0);
    repeat (4) @(negedge clk);
    chk("rstmid_buffered", int'(out_valid), 1);
    rst_n = 1'b0;
    #2;
    chk("rstmid_out_valid", int'(out_valid), 0);
    chk("rstmid_cfg_ready", int'(cfg_ready), 1);
    chk("rstmid_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("rstmid_no_stale", got_q.size(), 0);
    do_cfg(1);
    xv[0] = 5;
    load_vec(1);
    send_nz(-4, 0, 1, 1);
    wait_results(1);
    chk("post_rst_job", dat(got_q[0]), -20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
